ttl_serial_adder_accumulator: RTL

- Bit-serial, parametrised-width binary adder/subtractor with a registered result, start/busy/done handshake and carry/borrow flag.
- Generalises the fast-carry parallel adder family: one full-adder cell is reused over WIDTH clocks, as in the 74385 serial adder class of parts.
- Sits alongside the combinational adders in the 7400 library as a clocked arithmetic part for area-lean datapaths.

---
 rtl/ttl_serial_adder_pkg.sv | 15 +
 rtl/ttl_full_adder_bit.sv | 14 +
 rtl/ttl_serial_adder_accumulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ttl_serial_adder_pkg.sv
// rtl/ttl_serial_adder_pkg.sv - state encoding and counter sizing for the bit-serial adder
// Shared by ttl_serial_adder_accumulator (optional macro TTL_SERIAL_ADDER_OVERFLOW_EN lives in the top).
package ttl_serial_adder_pkg;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_SHIFT = 1'b1
  } state_t;

  // Counter must hold WIDTH itself after the final bit, so it is sized for WIDTH+1 values.
  function automatic int count_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ttl_full_adder_bit.sv
// rtl/ttl_full_adder_bit.sv - one-bit combinational full adder cell
// Reused once per clock by the serial adder datapath.
module ttl_full_adder_bit (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (A & C_in) | (B & C_in);

endmodule

// File: rtl/ttl_serial_adder_accumulator.sv
// rtl/ttl_serial_adder_accumulator.sv - bit-serial add/subtract with start/busy/done handshake
// Optional macro TTL_SERIAL_ADDER_OVERFLOW_EN adds a registered signed Overflow output.
module ttl_serial_adder_accumulator
  import ttl_serial_adder_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             Busy,
  output logic             Done
`ifdef TTL_SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = count_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, sub_q;
  logic             fa_s, fa_c;
  logic             accept, finish, last_bit;

  // Output delays are board-level timing annotations; the clocked RTL does not model them.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_negative_delay
  end

  ttl_full_adder_bit u_fa (
    .A     (op_a[0]),
    .B     (op_b[0]),
    .C_in  (carry),
    .S     (fa_s),
    .C_out (fa_c)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  if (WIDTH == 1) begin : g_res_one
    assign res_next = fa_s;
  end else begin : g_res_wide
    assign res_next = {fa_s, res[WIDTH-1:1]};
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = STATE_SHIFT;
        end
      end
      STATE_SHIFT: begin
        if (last_bit) begin
          finish     = 1'b1;
          state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state <= STATE_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      Sum   <= '0;
      C_out <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
`ifdef TTL_SERIAL_ADDER_OVERFLOW_EN
      Overflow <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        // Subtraction as A + ~B + ~borrow_in, so one adder cell serves both modes.
        op_a  <= A;
        op_b  <= Sub ? ~B : B;
        carry <= C_in ^ Sub;
        sub_q <= Sub;
        cnt   <= '0;
        Busy  <= 1'b1;
        Done  <= 1'b0;
      end else if (state == STATE_SHIFT) begin
        res   <= res_next;
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        carry <= fa_c;
        cnt   <= cnt + CW'(1);
        if (finish) begin
          Sum   <= res_next;
          C_out <= fa_c ^ sub_q;
          Busy  <= 1'b0;
          Done  <= 1'b1;
`ifdef TTL_SERIAL_ADDER_OVERFLOW_EN
          Overflow <= carry ^ fa_c;
`endif
        end
      end else begin
        Done <= 1'b0;
      end
    end
  end

endmodule
